// File: rtl/res_station_queue_pkg.sv
// Shared reservation-station types: dispatched words, CDB slots, ALU issue words and queue entries.
package tomasula_types;

  localparam int CPU_XLEN         = 32;
  localparam int ROB_TAG_W        = 3;
  localparam int RS_DEPTH_DEFAULT = 4;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } rv_opcode_e;

  typedef struct packed {
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [ROB_TAG_W-1:0] src1_tag;
    logic [CPU_XLEN-1:0]  src1_data;
    logic                 src1_valid;
    logic [ROB_TAG_W-1:0] src2_tag;
    logic [CPU_XLEN-1:0]  src2_data;
    logic                 src2_valid;
    logic [ROB_TAG_W-1:0] rd_tag;
    logic [CPU_XLEN-1:0]  pc;
  } res_word;

  typedef struct packed {
    logic [CPU_XLEN-1:0] data;
  } cdb_data;

  typedef struct packed {
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [ROB_TAG_W-1:0] tag;
    logic [CPU_XLEN-1:0]  pc;
    logic [CPU_XLEN-1:0]  src1_data;
    logic [CPU_XLEN-1:0]  src2_data;
  } alu_word;

  typedef struct packed {
    logic    valid;
    res_word word;
  } rs_entry_t;

endpackage

// File: rtl/res_station_queue_oldest_ready.sv
// Lowest-index priority picker; slot 0 holds the oldest entry, so the grant is the oldest ready one.
module rs_oldest_ready #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant,
  output logic             found
);

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/res_station_queue.sv
// Multi-entry, age-ordered reservation station in front of one ALU: CDB wakeup,
// oldest-ready issue, flush squash and collapsing compaction in a single edge.
module res_station_queue #(
  parameter int DEPTH       = tomasula_types::RS_DEPTH_DEFAULT,
  parameter int ROB_ENTRIES = 8,
  parameter int TAG_W       = 3,
  parameter int XLEN        = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_word,
  input  tomasula_types::res_word        res_in,
  input  tomasula_types::cdb_data        cdb [ROB_ENTRIES],
  input  logic [ROB_ENTRIES-1:0]         robs_calculated,
  input  logic [ROB_ENTRIES-1:0]         allocated_rob_entries,
  input  logic                           alu_ready,
  output tomasula_types::alu_word        alu_data,
  output logic                           start_exe,
  output logic                           jalr_executed,
  output logic                           ld_pc_to_cdb,
  output logic                           update_br,
  output logic                           res_empty,
  output logic                           res_full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  import tomasula_types::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  rs_entry_t        slots [DEPTH];
  rs_entry_t        nxt   [DEPTH];
  rs_entry_t        woken;
  rs_entry_t        incoming;
  res_word          sel;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] keep;
  logic             found;
  logic             issue;
  logic             accept;
  logic [CNT_W-1:0] kept;
  logic [CNT_W-1:0] next_count;
  logic [TAG_W-1:0] tag1;
  logic [TAG_W-1:0] tag2;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;

  // An entry is ready if each operand is held or appears on the CDB this cycle, and its ROB tag is live.
  always_comb begin
    ready = '0;
    keep  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = slots[i].valid
               & (slots[i].word.src1_valid | robs_calculated[slots[i].word.src1_tag])
               & (slots[i].word.src2_valid | robs_calculated[slots[i].word.src2_tag])
               & allocated_rob_entries[slots[i].word.rd_tag];
      keep[i]  = slots[i].valid
               & allocated_rob_entries[slots[i].word.rd_tag]
               & ~(issue & grant[i]);
    end
  end

  rs_oldest_ready #(.DEPTH(DEPTH)) u_pick (
    .req   (ready),
    .grant (grant),
    .found (found)
  );

  assign issue     = alu_ready & found & ~rst;
  assign start_exe = issue;
  assign res_empty = (count == '0);
  assign res_full  = (count == CNT_W'(DEPTH));
  assign accept    = load_word & ~res_full & allocated_rob_entries[res_in.rd_tag];

  // Issue mux with same-cycle CDB bypass for operands that have not been latched yet.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel = slots[i].word;
    end
    tag1          = sel.src1_tag;
    tag2          = sel.src2_tag;
    op1           = sel.src1_valid ? sel.src1_data : cdb[tag1].data;
    op2           = sel.src2_valid ? sel.src2_data : cdb[tag2].data;
    alu_data      = '0;
    jalr_executed = 1'b0;
    ld_pc_to_cdb  = 1'b0;
    update_br     = 1'b0;
    if (issue) begin
      alu_data.op        = sel.op;
      alu_data.funct3    = (sel.op == OP_JAL || sel.op == OP_JALR) ? 3'b000 : sel.funct3;
      alu_data.funct7    = sel.funct7;
      alu_data.tag       = sel.rd_tag;
      alu_data.pc        = sel.pc;
      alu_data.src1_data = op1;
      alu_data.src2_data = op2;
      case (sel.op)
        OP_JALR: begin
          jalr_executed = 1'b1;
          ld_pc_to_cdb  = 1'b1;
        end
        OP_JAL, OP_AUIPC: ld_pc_to_cdb = 1'b1;
        OP_BRANCH: begin
          ld_pc_to_cdb = 1'b1;
          update_br    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Survivors slide down to their prefix-count position; the new word lands right after them.
  always_comb begin
    nxt   = '{default: '0};
    woken = '0;
    kept  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woken = slots[i];
      if (!woken.word.src1_valid && robs_calculated[woken.word.src1_tag]) begin
        woken.word.src1_data  = cdb[woken.word.src1_tag].data;
        woken.word.src1_valid = 1'b1;
      end
      if (!woken.word.src2_valid && robs_calculated[woken.word.src2_tag]) begin
        woken.word.src2_data  = cdb[woken.word.src2_tag].data;
        woken.word.src2_valid = 1'b1;
      end
      if (keep[i]) begin
        nxt[kept] = woken;
        kept      = kept + CNT_W'(1);
      end
    end
    incoming            = '0;
    incoming.valid      = 1'b1;
    incoming.word       = res_in;
    incoming.word.src1_valid = res_in.src1_valid | robs_calculated[res_in.src1_tag];
    incoming.word.src1_data  = res_in.src1_valid ? res_in.src1_data : cdb[res_in.src1_tag].data;
    incoming.word.src2_valid = res_in.src2_valid | robs_calculated[res_in.src2_tag];
    incoming.word.src2_data  = res_in.src2_valid ? res_in.src2_data : cdb[res_in.src2_tag].data;
    if (accept) nxt[kept] = incoming;
    next_count = kept + CNT_W'(accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      count <= '0;
    end else begin
      slots <= nxt;
      count <= next_count;
    end
  end

endmodule

// File: tb/tb_res_station_queue.sv
// Directed, table-driven bench for res_station_queue: each vector drives one cycle and checks
// the combinational issue outputs plus the registered occupancy before the edge.
module tb_res_station_queue;

  import tomasula_types::*;

  typedef struct packed {
    logic       load;
    res_word    rw;
    logic       ardy;
    logic [7:0] alloc;
    logic [7:0] robs;
    logic       start;
    alu_word    aw;
    logic [2:0] side;
    logic [2:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_word;
  res_word    res_in;
  cdb_data    cdb [8];
  logic [7:0] robs_calculated;
  logic [7:0] allocated_rob_entries;
  logic       alu_ready;
  alu_word    alu_data;
  logic       start_exe;
  logic       jalr_executed;
  logic       ld_pc_to_cdb;
  logic       update_br;
  logic       res_empty;
  logic       res_full;
  logic [2:0] count;

  int nVec  = 0;
  int nCmp  = 0;
  int nFail = 0;
  vec_t vecs [$];

  always #5 clk = ~clk;

  res_station_queue #(.DEPTH(4), .ROB_ENTRIES(8), .TAG_W(3), .XLEN(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .load_word             (load_word),
    .res_in                (res_in),
    .cdb                   (cdb),
    .robs_calculated       (robs_calculated),
    .allocated_rob_entries (allocated_rob_entries),
    .alu_ready             (alu_ready),
    .alu_data              (alu_data),
    .start_exe             (start_exe),
    .jalr_executed         (jalr_executed),
    .ld_pc_to_cdb          (ld_pc_to_cdb),
    .update_br             (update_br),
    .res_empty             (res_empty),
    .res_full              (res_full),
    .count                 (count)
  );

  function automatic res_word w(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [2:0] s1t, input logic s1v, input logic [31:0] s1d,
                                input logic [2:0] s2t, input logic s2v, input logic [31:0] s2d,
                                input logic [2:0] rd, input logic [31:0] pc);
    res_word r;
    r.op = op; r.funct3 = f3; r.funct7 = f7;
    r.src1_tag = s1t; r.src1_valid = s1v; r.src1_data = s1d;
    r.src2_tag = s2t; r.src2_valid = s2v; r.src2_data = s2d;
    r.rd_tag = rd; r.pc = pc;
    return r;
  endfunction

  function automatic alu_word a(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [2:0] tag, input logic [31:0] pc,
                                input logic [31:0] s1, input logic [31:0] s2);
    alu_word r;
    r.op = op; r.funct3 = f3; r.funct7 = f7; r.tag = tag; r.pc = pc;
    r.src1_data = s1; r.src2_data = s2;
    return r;
  endfunction

  function automatic vec_t v(input logic load, input res_word rw, input logic ardy,
                             input logic [7:0] alloc, input logic [7:0] robs, input logic start,
                             input alu_word aw, input logic [2:0] side, input logic [2:0] cnt);
    vec_t r;
    r.load = load; r.rw = rw; r.ardy = ardy; r.alloc = alloc; r.robs = robs;
    r.start = start; r.aw = aw; r.side = side; r.cnt = cnt;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t t);
    load_word             = t.load;
    res_in                = t.rw;
    alu_ready             = t.ardy;
    allocated_rob_entries = t.alloc;
    robs_calculated       = t.robs;
  endtask

  task automatic chk(input string nm, input string field, input logic [127:0] act, input logic [127:0] expv);
    nCmp++;
    if (act !== expv) begin
      nFail++;
      $display("[TB] FAIL %s.%s got %0h expected %0h", nm, field, act, expv);
    end
  endtask

  task automatic checkOutput(input string nm, input vec_t t);
    nVec++;
    chk(nm, "start_exe", 128'(start_exe), 128'(t.start));
    chk(nm, "alu_data", 128'(alu_data), 128'(t.aw));
    chk(nm, "sideband", 128'({jalr_executed, ld_pc_to_cdb, update_br}), 128'(t.side));
    chk(nm, "count", 128'(count), 128'(t.cnt));
    chk(nm, "res_empty", 128'(res_empty), 128'(t.cnt == 3'd0));
    chk(nm, "res_full", 128'(res_full), 128'(t.cnt == 3'd4));
  endtask

  initial begin
    res_word nw;
    vec_t    idle0;
    nw = '0;
    for (int t = 0; t < 8; t++) cdb[t].data = 32'h1000 + t;
    cdb[3].data = 32'h10;
    idle0 = v(0, nw, 1, 8'hFF, 8'h00, 0, '0, 3'b000, 3'd0);

    // Reset state, then a single ready ADD through to empty
    vecs.push_back(idle0);
    vecs.push_back(v(1, w(OP_REG, 0, 7'h20, 0, 1, 32'd5, 0, 1, 32'd7, 2, 32'h10), 1, 8'hFF, 0, 0, '0, 0, 0));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_REG, 0, 7'h20, 2, 32'h10, 32'd5, 32'd7), 0, 1));
    vecs.push_back(idle0);
    // Younger ready word overtakes a waiting one; the waiting one latches CDB data later
    vecs.push_back(v(1, w(OP_REG, 0, 0, 3, 0, 0, 0, 1, 32'd1, 5, 32'h14), 0, 8'hFF, 0, 0, '0, 0, 0));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'd2, 0, 1, 32'd3, 4, 32'h18), 1, 8'hFF, 0, 0, '0, 0, 1));
    vecs.push_back(v(0, nw, 1, 8'hFF, 8'h00, 1, a(OP_REG, 0, 0, 4, 32'h18, 32'd2, 32'd3), 0, 2));
    vecs.push_back(v(0, nw, 0, 8'hFF, 8'h08, 0, '0, 0, 1));
    vecs.push_back(v(0, nw, 1, 8'hFF, 8'h00, 1, a(OP_REG, 0, 0, 5, 32'h14, 32'h10, 32'd1), 0, 1));
    vecs.push_back(idle0);
    // Fill to full, drop the fifth word even while issuing, drain in order
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h100, 0, 1, 32'h200, 1, 32'h20), 0, 8'hFF, 0, 0, '0, 0, 0));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h101, 0, 1, 32'h201, 2, 32'h24), 0, 8'hFF, 0, 0, '0, 0, 1));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h102, 0, 1, 32'h202, 3, 32'h28), 0, 8'hFF, 0, 0, '0, 0, 2));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h103, 0, 1, 32'h203, 6, 32'h2C), 0, 8'hFF, 0, 0, '0, 0, 3));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h104, 0, 1, 32'h204, 7, 32'h30), 0, 8'hFF, 0, 0, '0, 0, 4));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h104, 0, 1, 32'h204, 7, 32'h30), 1, 8'hFF, 0, 1, a(OP_REG, 0, 0, 1, 32'h20, 32'h100, 32'h200), 0, 4));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_REG, 0, 0, 2, 32'h24, 32'h101, 32'h201), 0, 3));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_REG, 0, 0, 3, 32'h28, 32'h102, 32'h202), 0, 2));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_REG, 0, 0, 6, 32'h2C, 32'h103, 32'h203), 0, 1));
    vecs.push_back(idle0);
    // Flush the middle entry of three
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h31, 0, 1, 32'h41, 1, 32'h54), 0, 8'hFF, 0, 0, '0, 0, 0));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h32, 0, 1, 32'h42, 2, 32'h58), 0, 8'hFF, 0, 0, '0, 0, 1));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h33, 0, 1, 32'h43, 3, 32'h5C), 0, 8'hFF, 0, 0, '0, 0, 2));
    vecs.push_back(v(0, nw, 0, 8'hFB, 0, 0, '0, 0, 3));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_REG, 0, 0, 1, 32'h54, 32'h31, 32'h41), 0, 2));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_REG, 0, 0, 3, 32'h5C, 32'h33, 32'h43), 0, 1));
    vecs.push_back(idle0);
    // Flush, issue and allocate in the same cycle
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h61, 0, 1, 32'h71, 1, 32'h84), 0, 8'hFF, 0, 0, '0, 0, 0));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h62, 0, 1, 32'h72, 2, 32'h88), 0, 8'hFF, 0, 0, '0, 0, 1));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h63, 0, 1, 32'h73, 3, 32'h8C), 0, 8'hFF, 0, 0, '0, 0, 2));
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'h64, 0, 1, 32'h74, 4, 32'h90), 1, 8'hF7, 0, 1, a(OP_REG, 0, 0, 1, 32'h84, 32'h61, 32'h71), 0, 3));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_REG, 0, 0, 2, 32'h88, 32'h62, 32'h72), 0, 2));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_REG, 0, 0, 4, 32'h90, 32'h64, 32'h74), 0, 1));
    vecs.push_back(idle0);
    // Side-band decode: JALR, BRANCH, JAL, AUIPC (AUIPC captures its operand from the CDB at dispatch)
    vecs.push_back(v(1, w(OP_JALR, 3'b010, 0, 0, 1, 32'h40, 0, 1, 0, 1, 32'h80), 0, 8'hFF, 0, 0, '0, 0, 0));
    vecs.push_back(v(1, w(OP_BRANCH, 3'b001, 0, 0, 1, 32'd9, 0, 1, 32'd9, 2, 32'h84), 1, 8'hFF, 0, 1, a(OP_JALR, 0, 0, 1, 32'h80, 32'h40, 0), 3'b110, 1));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_BRANCH, 3'b001, 0, 2, 32'h84, 32'd9, 32'd9), 3'b011, 1));
    vecs.push_back(v(1, w(OP_JAL, 3'b101, 0, 0, 1, 0, 0, 1, 0, 3, 32'h44), 1, 8'hFF, 0, 0, '0, 0, 0));
    vecs.push_back(v(1, w(OP_AUIPC, 3'b111, 0, 3, 0, 0, 0, 1, 0, 4, 32'h48), 1, 8'hFF, 8'h08, 1, a(OP_JAL, 0, 0, 3, 32'h44, 0, 0), 3'b010, 1));
    vecs.push_back(v(0, nw, 1, 8'hFF, 0, 1, a(OP_AUIPC, 3'b111, 0, 4, 32'h48, 32'h10, 0), 3'b010, 1));
    // Dispatch to a dead ROB tag is dropped
    vecs.push_back(v(1, w(OP_REG, 0, 0, 0, 1, 32'd1, 0, 1, 32'd1, 6, 32'h90), 0, 8'hBF, 0, 0, '0, 0, 0));
    vecs.push_back(idle0);
    // Same-cycle CDB bypass at issue
    vecs.push_back(v(1, w(OP_REG, 0, 0, 5, 0, 0, 0, 1, 32'd2, 7, 32'hA0), 1, 8'hFF, 0, 0, '0, 0, 0));
    vecs.push_back(v(0, nw, 1, 8'hFF, 8'h20, 1, a(OP_REG, 0, 0, 7, 32'hA0, 32'h1005, 32'd2), 0, 1));
    vecs.push_back(idle0);

    rst = 1'b1;
    applyStimulus(v(0, nw, 0, 8'hFF, 0, 0, '0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d", i), vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset with three valid entries and the ALU ready discards them all
    for (int k = 0; k < 3; k++) begin
      applyStimulus(v(1, w(OP_REG, 0, 0, 0, 1, 32'd1, 0, 1, 32'd2, 3'(k + 1), 32'hB0), 0, 8'hFF, 0, 0, '0, 0, 0));
      @(posedge clk);
      #1;
    end
    applyStimulus(v(0, nw, 0, 8'hFF, 0, 0, '0, 0, 3));
    @(negedge clk);
    checkOutput("pre_rst", v(0, nw, 0, 8'hFF, 0, 0, '0, 0, 3));
    applyStimulus(v(0, nw, 1, 8'hFF, 0, 0, '0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst", v(0, nw, 1, 8'hFF, 0, 0, '0, 0, 0));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("post_rst2", v(0, nw, 1, 8'hFF, 0, 0, '0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
